clock_set_ctrl: RTL and testbench

Controller that sequences the clock/calendar datapath from the two front-panel keys. It debounces `key_mode` and `key_add`, runs the display/set mode state machine, and gates the timekeeping run flag. It issues single-cycle increment commands to the minute, hour, day and month counters, and drives the blink enable used by the segment display during setting. It sits between the raw `ui_in` key pins and the time counters and data-show mux in the top level.

---
 rtl/clock_ctrl_pkg.sv | 39 +++
 rtl/key_debounce.sv | 65 ++++++
 rtl/clock_set_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: mode encoding, status type and default timing
// constants shared by the clock/calendar set controller.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_SHOW_TIME  = 3'd0,
        ST_SHOW_DATE  = 3'd1,
        ST_SET_MINUTE = 3'd2,
        ST_SET_HOUR   = 3'd3,
        ST_SET_DAY    = 3'd4,
        ST_SET_MONTH  = 3'd5,
        ST_STOP       = 3'd6
    } status_t;

    localparam int DEF_DB_CYCLES     = 1024;
    localparam int DEF_REPEAT_DELAY  = 32768;
    localparam int DEF_REPEAT_PERIOD = 8192;
    localparam int DEF_BLINK_CYCLES  = 16384;

    // True in the four modes where the add key edits a field.
    function automatic logic is_set_state(input status_t s);
        return (s == ST_SET_MINUTE) || (s == ST_SET_HOUR) ||
               (s == ST_SET_DAY)    || (s == ST_SET_MONTH);
    endfunction

    // Mode sequence advanced by each mode-key press; STOP wraps home.
    function automatic status_t next_mode(input status_t s);
        case (s)
            ST_SHOW_TIME:  return ST_SHOW_DATE;
            ST_SHOW_DATE:  return ST_SET_MINUTE;
            ST_SET_MINUTE: return ST_SET_HOUR;
            ST_SET_HOUR:   return ST_SET_DAY;
            ST_SET_DAY:    return ST_SET_MONTH;
            ST_SET_MONTH:  return ST_STOP;
            default:       return ST_SHOW_TIME;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, stable-count debouncer and
// one-cycle press pulse for a single raw front-panel key.
module key_debounce
    import clock_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_level,
    output logic o_down
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_down;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // One-cycle pulse on each accepted 0->1 transition.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level_d <= 1'b0;
            r_down    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_down    <= r_level & ~r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_down  = r_down;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: key-driven mode FSM, increment commands and blink
// for the clock/calendar. CLOCK_SET_AUTOREPEAT_EN adds hold-to-repeat.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int BLINK_CYCLES  = DEF_BLINK_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_add,
    output logic [2:0] status,
    output logic       clock_run_flag,
    output logic       clear_second,
    output logic       inc_minute,
    output logic       inc_hour,
    output logic       inc_day,
    output logic       inc_month,
    output logic       key_mode_down,
    output logic       key_add_down,
    output logic       blink
);

    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic          w_mode_level;
    logic          w_mode_down;
    logic          w_add_level;
    logic          w_add_down;
    logic          w_unused_levels;
    status_t       w_next_status;
    logic          w_state_chg;
    logic          w_rep_fire;
    logic          w_add_evt;

    status_t       r_status;
    logic          r_run;
    logic          r_clear;
    logic          r_inc_minute;
    logic          r_inc_hour;
    logic          r_inc_day;
    logic          r_inc_month;
    logic          r_blink;
    logic [BW-1:0] r_blink_cnt;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_mode (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_key   (key_mode),
        .o_level (w_mode_level),
        .o_down  (w_mode_down)
    );

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_add (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_key   (key_add),
        .o_level (w_add_level),
        .o_down  (w_add_down)
    );

    assign w_unused_levels = w_mode_level ^ w_add_level;

    // Next mode: advance on a mode press, recover from the illegal code.
    always_comb begin
        w_next_status = r_status;
        case (r_status)
            ST_SHOW_TIME, ST_SHOW_DATE, ST_SET_MINUTE, ST_SET_HOUR,
            ST_SET_DAY, ST_SET_MONTH, ST_STOP: begin
                if (w_mode_down) begin
                    w_next_status = next_mode(r_status);
                end
            end
            default: w_next_status = ST_SHOW_TIME;
        endcase
    end

    assign w_state_chg = (w_next_status != r_status);

    // Mode register with its run flag and seconds-clear pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_status <= ST_SHOW_TIME;
            r_run    <= 1'b1;
            r_clear  <= 1'b0;
        end else begin
            r_status <= w_next_status;
            r_run    <= (w_next_status == ST_SHOW_TIME) ||
                        (w_next_status == ST_SHOW_DATE);
            r_clear  <= w_state_chg && (w_next_status == ST_SET_MINUTE);
        end
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          w_rep_run;
    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_armed;

    assign w_rep_run = w_add_level && is_set_state(r_status) &&
                       !w_state_chg;

    assign w_rep_fire = w_rep_run &&
                        (r_rep_armed ? (r_rep_cnt == PERIOD_LAST)
                                     : (r_rep_cnt == DELAY_LAST));

    // Hold timer: initial delay, then a fixed period while held.
    always_ff @(posedge clock) begin
        if (reset || !w_rep_run) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // A mode press in the same cycle discards the add event.
    assign w_add_evt = is_set_state(r_status) && !w_mode_down &&
                       (w_add_down || w_rep_fire);

    // Route each add event to the field being edited.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inc_minute <= 1'b0;
            r_inc_hour   <= 1'b0;
            r_inc_day    <= 1'b0;
            r_inc_month  <= 1'b0;
        end else begin
            r_inc_minute <= w_add_evt && (r_status == ST_SET_MINUTE);
            r_inc_hour   <= w_add_evt && (r_status == ST_SET_HOUR);
            r_inc_day    <= w_add_evt && (r_status == ST_SET_DAY);
            r_inc_month  <= w_add_evt && (r_status == ST_SET_MONTH);
        end
    end

    // Blink restarts high on every mode change, toggles while setting.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_state_chg) begin
            r_blink     <= is_set_state(w_next_status);
            r_blink_cnt <= '0;
        end else if (is_set_state(r_status)) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end else begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end
    end

    assign status         = r_status;
    assign clock_run_flag = r_run;
    assign clear_second   = r_clear;
    assign inc_minute     = r_inc_minute;
    assign inc_hour       = r_inc_hour;
    assign inc_day        = r_inc_day;
    assign inc_month      = r_inc_month;
    assign key_mode_down  = w_mode_down;
    assign key_add_down   = w_add_down;
    assign blink          = r_blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed bench for clock_set_ctrl with
// DB=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK=8.
module tb_clock_set_ctrl;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_add  = 1'b0;
    logic [2:0] status;
    logic       clock_run_flag;
    logic       clear_second;
    logic       inc_minute;
    logic       inc_hour;
    logic       inc_day;
    logic       inc_month;
    logic       key_mode_down;
    logic       key_add_down;
    logic       blink;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    int n_md, n_ad, n_clr, n_im, n_ih, n_id, n_imo, n_multi, n_runbad;
    int c_md, c_ad, c_clr, c_ih, c_im_first, c_im_last, c_st2, c_chg;
    logic [2:0] prev_st = 3'd0;

    clock_set_ctrl #(
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5),
        .BLINK_CYCLES  (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .key_mode       (key_mode),
        .key_add        (key_add),
        .status         (status),
        .clock_run_flag (clock_run_flag),
        .clear_second   (clear_second),
        .inc_minute     (inc_minute),
        .inc_hour       (inc_hour),
        .inc_day        (inc_day),
        .inc_month      (inc_month),
        .key_mode_down  (key_mode_down),
        .key_add_down   (key_add_down),
        .blink          (blink)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (key_mode_down) begin n_md++; c_md = cyc; end
        if (key_add_down) begin n_ad++; c_ad = cyc; end
        if (clear_second) begin n_clr++; c_clr = cyc; end
        if (inc_minute) begin
            if (n_im == 0) c_im_first = cyc;
            n_im++;
            c_im_last = cyc;
        end
        if (inc_hour) begin n_ih++; c_ih = cyc; end
        if (inc_day) n_id++;
        if (inc_month) n_imo++;
        if (int'(inc_minute) + int'(inc_hour) + int'(inc_day) +
            int'(inc_month) > 1) n_multi++;
        if (status !== prev_st) begin
            c_chg = cyc;
            if (status === 3'd2) c_st2 = cyc;
        end
        prev_st = status;
        if (clock_run_flag !== (status < 3'd2)) n_runbad++;
    end

    initial begin
        #400000;
        $display("FAIL timeout: run did not finish in time");
        $fatal(1);
    end

    task automatic clr_mon();
        n_md = 0; n_ad = 0; n_clr = 0; n_im = 0; n_ih = 0;
        n_id = 0; n_imo = 0; n_multi = 0; n_runbad = 0;
        c_md = -1; c_ad = -1; c_clr = -1; c_ih = -1;
        c_im_first = -1; c_im_last = -1; c_st2 = -1; c_chg = -1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; key_mode = 1'b0; key_add = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        clr_mon();
    endtask

    task automatic press(input logic m, input logic a, input int hold,
                         output int t0);
        @(negedge clock);
        key_mode = m; key_add = a; t0 = cyc;
        repeat (hold) @(negedge clock);
        key_mode = 1'b0; key_add = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    task automatic goto_modes(input int n);
        int t;
        for (int i = 0; i < n; i++) press(1'b1, 1'b0, 6, t);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (status !== 3'd0) begin errs++;
            $display("FAIL reset_status: got %0d want 0", status); end
        checks++;
        if (clock_run_flag !== 1'b1) begin errs++;
            $display("FAIL reset_run: got %b want 1", clock_run_flag); end
        checks++;
        if (blink !== 1'b0) begin errs++;
            $display("FAIL reset_blink: got %b want 0", blink); end
        checks++;
        if ({clear_second, inc_minute, inc_hour, inc_day, inc_month,
             key_mode_down, key_add_down} !== 7'b0) begin errs++;
            $display("FAIL reset_pulses: got %b want 0000000",
                {clear_second, inc_minute, inc_hour, inc_day, inc_month,
                 key_mode_down, key_add_down}); end
    endtask

    task automatic test_bounce();
        int t;
        do_reset();
        @(negedge clock);
        for (int i = 0; i < 12; i++) begin
            key_mode = ((i % 4) < 2);
            @(negedge clock);
        end
        key_mode = 1'b1; t = cyc;
        repeat (12) @(negedge clock);
        key_mode = 1'b0;
        repeat (12) @(negedge clock);
        checks++;
        if (n_md !== 1) begin errs++;
            $display("FAIL bounce_count: got %0d want 1", n_md); end
        checks++;
        if (c_md !== t + 7) begin errs++;
            $display("FAIL bounce_latency: got %0d want %0d", c_md - t, 7); end
        checks++;
        if (status !== 3'd1) begin errs++;
            $display("FAIL bounce_status: got %0d want 1", status); end
    endtask

    task automatic test_mode_seq();
        int t;
        int exp_st[7] = '{1, 2, 3, 4, 5, 6, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            press(1'b1, 1'b0, 6, t);
            checks++;
            if (status !== 3'(exp_st[i])) begin errs++;
                $display("FAIL seq_status[%0d]: got %0d want %0d",
                    i, status, exp_st[i]); end
            checks++;
            if (clock_run_flag !== (exp_st[i] < 2)) begin errs++;
                $display("FAIL seq_run[%0d]: got %b want %b",
                    i, clock_run_flag, exp_st[i] < 2); end
            checks++;
            if (c_chg !== t + 8) begin errs++;
                $display("FAIL seq_latency[%0d]: got %0d want %0d",
                    i, c_chg - t, 8); end
        end
        checks++;
        if (n_clr !== 1) begin errs++;
            $display("FAIL clear_count: got %0d want 1", n_clr); end
        checks++;
        if (c_clr !== c_st2) begin errs++;
            $display("FAIL clear_cycle: got %0d want %0d", c_clr, c_st2); end
        checks++;
        if (n_runbad !== 0) begin errs++;
            $display("FAIL run_flag_track: got %0d bad cycles want 0",
                n_runbad); end
    endtask

    task automatic test_add_hour();
        int t;
        do_reset();
        goto_modes(3);
        checks++;
        if (status !== 3'd3) begin errs++;
            $display("FAIL hour_setup: got %0d want 3", status); end
        clr_mon();
        press(1'b0, 1'b1, 6, t);
        checks++;
        if (n_ih !== 1) begin errs++;
            $display("FAIL hour_count: got %0d want 1", n_ih); end
        checks++;
        if (c_ih !== c_ad + 1) begin errs++;
            $display("FAIL hour_latency: got %0d want %0d", c_ih, c_ad + 1); end
        checks++;
        if (c_ad !== t + 7) begin errs++;
            $display("FAIL add_latency: got %0d want %0d", c_ad - t, 7); end
        checks++;
        if (n_im + n_id + n_imo !== 0) begin errs++;
            $display("FAIL hour_others: got %0d want 0", n_im + n_id + n_imo); end
        checks++;
        if (n_multi !== 0) begin errs++;
            $display("FAIL inc_onehot: got %0d want 0", n_multi); end
    endtask

    task automatic test_add_idle();
        int t;
        do_reset();
        press(1'b0, 1'b1, 6, t);
        checks++;
        if (n_ad !== 1) begin errs++;
            $display("FAIL idle_add_down: got %0d want 1", n_ad); end
        checks++;
        if (n_im + n_ih + n_id + n_imo !== 0) begin errs++;
            $display("FAIL idle_inc: got %0d want 0",
                n_im + n_ih + n_id + n_imo); end
    endtask

    task automatic test_simul();
        int t;
        do_reset();
        goto_modes(2);
        clr_mon();
        press(1'b1, 1'b1, 6, t);
        checks++;
        if (status !== 3'd3) begin errs++;
            $display("FAIL simul_status: got %0d want 3", status); end
        checks++;
        if (n_im !== 0) begin errs++;
            $display("FAIL simul_minute: got %0d want 0", n_im); end
        checks++;
        if (n_ih !== 0) begin errs++;
            $display("FAIL simul_hour: got %0d want 0", n_ih); end
        checks++;
        if (c_md !== c_ad) begin errs++;
            $display("FAIL simul_same_cycle: got %0d want %0d", c_ad, c_md); end
    endtask

    task automatic test_autorepeat();
        int t;
        int exp_n;
        int exp_last;
`ifdef CLOCK_SET_AUTOREPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        do_reset();
        goto_modes(2);
        clr_mon();
        press(1'b0, 1'b1, 33, t);
        repeat (10) @(negedge clock);
        exp_last = (exp_n == 4) ? t + 36 : t + 8;
        checks++;
        if (n_im !== exp_n) begin errs++;
            $display("FAIL repeat_count: got %0d want %0d", n_im, exp_n); end
        checks++;
        if (c_im_first !== t + 8) begin errs++;
            $display("FAIL repeat_first: got %0d want %0d",
                c_im_first - t, 8); end
        checks++;
        if (c_im_last !== exp_last) begin errs++;
            $display("FAIL repeat_last: got %0d want %0d",
                c_im_last - t, exp_last - t); end
    endtask

    task automatic test_blink();
        int t;
        do_reset();
        goto_modes(1);
        checks++;
        if (blink !== 1'b0) begin errs++;
            $display("FAIL blink_show: got %b want 0", blink); end
        @(negedge clock);
        key_mode = 1'b1; t = cyc;
        repeat (8) @(negedge clock);
        checks++;
        if ({status, blink} !== {3'd2, 1'b1}) begin errs++;
            $display("FAIL blink_entry: got st=%0d b=%b want st=2 b=1",
                status, blink); end
        repeat (7) @(negedge clock);
        checks++;
        if (blink !== 1'b1) begin errs++;
            $display("FAIL blink_high_end: got %b want 1", blink); end
        @(negedge clock);
        checks++;
        if (blink !== 1'b0) begin errs++;
            $display("FAIL blink_toggle: got %b want 0", blink); end
        key_mode = 1'b0;
        repeat (10) @(negedge clock);
        key_mode = 1'b1; t = cyc;
        repeat (8) @(negedge clock);
        checks++;
        if ({status, blink} !== {3'd3, 1'b1}) begin errs++;
            $display("FAIL blink_restart: got st=%0d b=%b want st=3 b=1",
                status, blink); end
        key_mode = 1'b0;
        repeat (10) @(negedge clock);
        goto_modes(3);
        checks++;
        if ({status, blink, clock_run_flag} !== {3'd6, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL blink_stop: got st=%0d b=%b r=%b want 6 0 0",
                status, blink, clock_run_flag); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        goto_modes(2);
        @(negedge clock);
        key_add = 1'b1;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({status, clock_run_flag, blink, clear_second, inc_minute,
             key_add_down} !== {3'd0, 1'b1, 4'b0}) begin errs++;
            $display("FAIL midhold_reset_cycle: got st=%0d r=%b b=%b m=%b",
                status, clock_run_flag, blink, inc_minute); end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({inc_minute, inc_hour, clear_second, key_add_down,
             status} !== {4'b0, 3'd0}) begin errs++;
            $display("FAIL midhold_after: got m=%b h=%b st=%0d want 0 0 0",
                inc_minute, inc_hour, status); end
        clr_mon();
        repeat (12) @(negedge clock);
        key_add = 1'b0;
        repeat (10) @(negedge clock);
        checks++;
        if (n_ad !== 1) begin errs++;
            $display("FAIL held_through_reset: got %0d want 1", n_ad); end
        checks++;
        if (n_im + n_ih !== 0) begin errs++;
            $display("FAIL held_inc: got %0d want 0", n_im + n_ih); end
    endtask

    initial begin
        clr_mon();
        test_reset();
        test_bounce();
        test_mode_seq();
        test_add_hour();
        test_add_idle();
        test_simul();
        test_autorepeat();
        test_blink();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
